// File: rtl/pipeline_pkg.sv
// Shared state type and constants for the pipeline control slice.
package pipeline_pkg;

    typedef enum logic [1:0] {
        RUN,
        HALT,
        RESUME
    } pctl_state_t;

    localparam logic [4:0]  REG_ZERO  = 5'd0;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard check between the ID instruction and a load in EX.
module hazard_detect
    import pipeline_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    output logic       lu
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = id_uses_rs && (id_rs == ex_rt);
    assign rt_hit = id_uses_rt && (id_rt == ex_rt);
    assign lu     = ex_mem_read && (ex_rt != REG_ZERO) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: hazard stalls, wrong-path flushes, halt/resume
// freeze and statistics counters.
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_jump,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    input  logic             wb_halt,
    input  logic             resume,
    output logic             pc_go,
    output logic             if_id_go,
    output logic             if_id_clear,
    output logic             id_ex_go,
    output logic             id_ex_clear,
    output logic             ex_mem_go,
    output logic             mem_wb_go,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    pctl_state_t state;
    pctl_state_t state_nx;
    logic        resume_q;
    logic        resume_rise;
    logic        lu;
    logic        do_stall;
    logic        do_flush;

    hazard_detect u_hazard (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rs  (id_uses_rs),
        .id_uses_rt  (id_uses_rt),
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .lu          (lu)
    );

    assign resume_rise = resume && !resume_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            resume_q <= 1'b1;
        end else begin
            state    <= state_nx;
            resume_q <= resume;
        end
    end

    always_comb begin
        state_nx    = state;
        pc_go       = 1'b1;
        if_id_go    = 1'b1;
        if_id_clear = 1'b0;
        id_ex_go    = 1'b1;
        id_ex_clear = 1'b0;
        ex_mem_go   = 1'b1;
        mem_wb_go   = 1'b1;
        do_stall    = 1'b0;
        do_flush    = 1'b0;
        halted      = (state == HALT);

        unique case (state)
            RUN:     if (wb_halt) state_nx = HALT;
            HALT:    if (resume_rise) state_nx = RESUME;
            RESUME:  state_nx = RUN;
            default: state_nx = RUN;
        endcase

        if (state == HALT) begin
            pc_go     = 1'b0;
            if_id_go  = 1'b0;
            id_ex_go  = 1'b0;
            ex_mem_go = 1'b0;
            mem_wb_go = 1'b0;
        end else if (ex_branch_taken) begin
            if_id_clear = 1'b1;
            id_ex_clear = 1'b1;
            do_flush    = 1'b1;
        end else if (lu) begin
            pc_go       = 1'b0;
            if_id_go    = 1'b0;
            id_ex_clear = 1'b1;
            do_stall    = 1'b1;
        end else if (id_jump) begin
            if_id_clear = 1'b1;
            do_flush    = 1'b1;
        end

        // Load zeros into every buffer while reset is held.
        if (rst) begin
            pc_go       = 1'b0;
            if_id_go    = 1'b1;
            if_id_clear = 1'b1;
            id_ex_go    = 1'b1;
            id_ex_clear = 1'b1;
            ex_mem_go   = 1'b1;
            mem_wb_go   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (state != HALT) cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (do_stall)      stall_cnt <= stall_cnt + CNT_W'(1);
            if (do_flush)      flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with a behavioural reference model.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rs, id_uses_rt, id_jump;
    logic        ex_mem_read, ex_branch_taken, wb_halt, resume;
    logic        pc_go, if_id_go, if_id_clear, id_ex_go, id_ex_clear;
    logic        ex_mem_go, mem_wb_go, halted;
    logic [31:0] cycle_cnt, stall_cnt, flush_cnt;

    int n_chk = 0;
    int n_pass = 0;

    // pc_go, if_id_go, if_id_clear, id_ex_go, id_ex_clear, ex_mem_go, mem_wb_go, halted
    localparam logic [7:0] C_RESET  = 8'b0111_1110;
    localparam logic [7:0] C_FROZEN = 8'b0000_0001;
    localparam logic [7:0] C_BRANCH = 8'b1111_1110;
    localparam logic [7:0] C_STALL  = 8'b0001_1110;
    localparam logic [7:0] C_JUMP   = 8'b1111_0110;
    localparam logic [7:0] C_NORMAL = 8'b1101_0110;

    logic [7:0] ctl;
    assign ctl = {pc_go, if_id_go, if_id_clear, id_ex_go, id_ex_clear,
                  ex_mem_go, mem_wb_go, halted};

    pipeline_ctrl #(.CNT_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .id_jump         (id_jump),
        .ex_mem_read     (ex_mem_read),
        .ex_rt           (ex_rt),
        .ex_branch_taken (ex_branch_taken),
        .wb_halt         (wb_halt),
        .resume          (resume),
        .pc_go           (pc_go),
        .if_id_go        (if_id_go),
        .if_id_clear     (if_id_clear),
        .id_ex_go        (id_ex_go),
        .id_ex_clear     (id_ex_clear),
        .ex_mem_go       (ex_mem_go),
        .mem_wb_go       (mem_wb_go),
        .halted          (halted),
        .cycle_cnt       (cycle_cnt),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    endtask

    // Reference model: frozen flag, one-cycle "just woke" flag, key history.
    logic        m_frozen, m_woke, m_prev;
    logic [31:0] m_cyc, m_st, m_fl;

    function automatic logic m_lu();
        if (!ex_mem_read || ex_rt == 5'd0) return 1'b0;
        return (id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt);
    endfunction

    function automatic logic [7:0] exp_ctl();
        if (rst) return C_RESET;
        if (m_frozen) return C_FROZEN;
        if (ex_branch_taken) return C_BRANCH;
        if (m_lu()) return C_STALL;
        if (id_jump) return C_JUMP;
        return C_NORMAL;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_frozen <= 1'b0;
            m_woke   <= 1'b0;
            m_prev   <= 1'b1;
            m_cyc    <= '0;
            m_st     <= '0;
            m_fl     <= '0;
        end else begin
            if (!m_frozen) begin
                m_cyc <= m_cyc + 1;
                if (ex_branch_taken || (!m_lu() && id_jump)) m_fl <= m_fl + 1;
                else if (m_lu()) m_st <= m_st + 1;
            end
            if (m_frozen) begin
                if (resume && !m_prev) begin
                    m_frozen <= 1'b0;
                    m_woke   <= 1'b1;
                end
            end else if (m_woke) begin
                m_woke <= 1'b0;
            end else if (wb_halt) begin
                m_frozen <= 1'b1;
            end
            m_prev <= resume;
        end
    end

    always @(negedge clk) begin
        chk("ctl", {24'd0, ctl}, {24'd0, exp_ctl()});
        chk("cycle_cnt", cycle_cnt, m_cyc);
        chk("stall_cnt", stall_cnt, m_st);
        chk("flush_cnt", flush_cnt, m_fl);
    end

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_jump = 1'b0;
        ex_mem_read = 1'b0; ex_branch_taken = 1'b0; wb_halt = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] r);
        ex_mem_read = 1'b1; ex_rt = r; id_rs = r; id_uses_rs = 1'b1;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] frozen_cyc;

    initial begin
        rst = 1'b1;
        resume = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ctl", {24'd0, ctl}, {24'd0, C_RESET});
        chk("reset_cycle", cycle_cnt, 32'd0);
        next(); rst = 1'b0;
        @(negedge clk);
        chk("idle_ctl", {24'd0, ctl}, {24'd0, C_NORMAL});

        next(); set_lu(5'd8);
        @(negedge clk);
        chk("lu_ctl", {24'd0, ctl}, {24'd0, C_STALL});
        next(); idle();
        @(negedge clk);
        chk("lu_stall_cnt", stall_cnt, 32'd1);

        next(); set_lu(5'd0);
        @(negedge clk);
        chk("zero_ctl", {24'd0, ctl}, {24'd0, C_NORMAL});
        next(); idle();
        @(negedge clk);
        chk("zero_stall_cnt", stall_cnt, 32'd1);

        next(); set_lu(5'd9); ex_branch_taken = 1'b1; id_jump = 1'b1;
        @(negedge clk);
        chk("br_ctl", {24'd0, ctl}, {24'd0, C_BRANCH});
        next(); idle();
        @(negedge clk);
        chk("br_flush_cnt", flush_cnt, 32'd1);
        chk("br_stall_cnt", stall_cnt, 32'd1);

        next(); id_jump = 1'b1;
        @(negedge clk);
        chk("jump_ctl", {24'd0, ctl}, {24'd0, C_JUMP});
        next(); ex_mem_read = 1'b1; ex_rt = 5'd3; id_rt = 5'd3; id_uses_rt = 1'b1;
        @(negedge clk);
        chk("jump_lu_ctl", {24'd0, ctl}, {24'd0, C_STALL});
        next(); idle();
        @(negedge clk);
        chk("jump_flush_cnt", flush_cnt, 32'd2);
        chk("jump_stall_cnt", stall_cnt, 32'd2);

        next(); wb_halt = 1'b1;
        @(negedge clk);
        chk("pre_halt", {31'd0, halted}, 32'd0);
        next();
        @(negedge clk);
        chk("halt_ctl", {24'd0, ctl}, {24'd0, C_FROZEN});
        frozen_cyc = m_cyc;
        repeat (2) next();
        @(negedge clk);
        chk("halt_cyc_frozen", cycle_cnt, frozen_cyc);
        next(); resume = 1'b1;
        @(negedge clk);
        chk("halt_still", {31'd0, halted}, 32'd1);
        next();
        @(negedge clk);
        chk("resume_ctl", {24'd0, ctl}, {24'd0, C_NORMAL});
        next(); wb_halt = 1'b0;
        @(negedge clk);
        chk("run_after_resume", {31'd0, halted}, 32'd0);

        next(); wb_halt = 1'b1;
        next(); wb_halt = 1'b0;
        repeat (3) next();
        @(negedge clk);
        chk("held_resume_halt", {31'd0, halted}, 32'd1);
        resume = 1'b0;
        next(); resume = 1'b1;
        @(negedge clk);
        chk("held_still_halt", {31'd0, halted}, 32'd1);
        next();
        @(negedge clk);
        chk("held_resumed", {31'd0, halted}, 32'd0);

        next(); wb_halt = 1'b1;
        next(); wb_halt = 1'b0;
        @(negedge clk);
        chk("pre_rst_halt", {31'd0, halted}, 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_halted", {31'd0, halted}, 32'd0);
        chk("arst_cycle", cycle_cnt, 32'd0);
        chk("arst_flush", flush_cnt, 32'd0);
        chk("arst_ctl", {24'd0, ctl}, {24'd0, C_RESET});
        next(); rst = 1'b0;
        repeat (3) next();
        @(negedge clk);
        chk("post_rst_cycle", cycle_cnt, 32'd3);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
